oam_dma_arbiter_mod: RTL and testbench

Owns the shared 16-bit system memory bus between the CPU and the OAM DMA engine. It decodes CPU writes to the DMA register and copies 160 bytes from a source page into OAM (FE00-FE9F). While a copy runs it blocks CPU bus accesses. It sits between the CPU core (sequenced by control_unit_mod) and the memory/IO decoder.

---
 rtl/oam_dma_arbiter_mod_pkg.sv | 24 ++
 rtl/oam_dma_engine_mod.sv | 80 ++++++++
 rtl/oam_dma_arbiter_mod.sv | 70 +++++++
 tb/tb_oam_dma_arbiter_mod.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_arbiter_mod_pkg.sv
// Shared types and constants for the CPU / OAM-DMA bus arbiter.
package oam_dma_arbiter_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned XFER_LEN     = 160;
  localparam logic [7:0]  LAST_IDX     = 8'(XFER_LEN - 1);
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;
  localparam logic [7:0]  ECHO_MASK    = 8'hDF;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;

  // Echo pages E0-FF alias work RAM at C0-DF.
  function automatic logic [7:0] echo_fold(input logic [7:0] page);
    return (page >= ECHO_BASE) ? (page & ECHO_MASK) : page;
  endfunction

endpackage

// File: rtl/oam_dma_engine_mod.sv
// OAM DMA engine: trigger -> SETUP -> XFER_LEN x (READ, WRITE) -> IDLE; a trigger restarts from any state.
// Build option OAM_DMA_READBACK_EN: o_reg_rdata returns the page register instead of open bus.
module oam_dma_engine_mod
  import oam_dma_arbiter_mod_pkg::*;
#(
  parameter int SETUP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_trig,
  input  logic [7:0] i_trig_page,
  input  logic [7:0] i_mem_rdata,
  output dma_state_e o_state,
  output logic [7:0] o_src_page,
  output logic [7:0] o_index,
  output logic [7:0] o_latch,
  output logic [7:0] o_reg_rdata
);

  localparam logic [7:0] SETUP_CNT_INIT = 8'(SETUP_CYCLES - 1);

  dma_state_e r_state;
  dma_state_e w_state_nxt;
  logic [7:0] r_page;
  logic [7:0] r_index;
  logic [7:0] r_setup_cnt;
  logic [7:0] r_latch;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_SETUP: if (r_setup_cnt == 8'd0) w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = (r_index == LAST_IDX) ? ST_IDLE : ST_READ;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // A new trigger wins over every transition, including the final WRITE.
    if (i_trig) w_state_nxt = ST_SETUP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_page      <= 8'h00;
      r_index     <= 8'h00;
      r_setup_cnt <= 8'h00;
      r_latch     <= 8'h00;
    end else begin
      if (r_state == ST_READ) r_latch <= i_mem_rdata;
      if (i_trig) begin
        r_page      <= i_trig_page;
        r_index     <= 8'h00;
        r_setup_cnt <= SETUP_CNT_INIT;
      end else begin
        if (r_state == ST_SETUP && r_setup_cnt != 8'd0) r_setup_cnt <= r_setup_cnt - 8'd1;
        if (r_state == ST_WRITE && r_index != LAST_IDX) r_index <= r_index + 8'd1;
      end
    end
  end

  assign o_state    = r_state;
  assign o_src_page = echo_fold(r_page);
  assign o_index    = r_index;
  assign o_latch    = r_latch;

`ifdef OAM_DMA_READBACK_EN
  assign o_reg_rdata = r_page;
`else
  assign o_reg_rdata = OPEN_BUS;
`endif

endmodule

// File: rtl/oam_dma_arbiter_mod.sv
// Shared-bus arbiter: decodes the DMA register and muxes CPU vs OAM-DMA onto mem_*.
// DMA register readback is selected by OAM_DMA_READBACK_EN inside the engine.
module oam_dma_arbiter_mod
  import oam_dma_arbiter_mod_pkg::*;
#(
  parameter int SETUP_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  dma_state_e w_state;
  logic [7:0] w_src_page;
  logic [7:0] w_index;
  logic [7:0] w_latch;
  logic [7:0] w_reg_rdata;
  logic       w_reg_hit;
  logic       w_trig;
  logic       w_dma_owns;

  assign w_reg_hit = (cpu_addr == DMA_REG_ADDR);
  assign w_trig    = cpu_wr && w_reg_hit;

  oam_dma_engine_mod #(
    .SETUP_CYCLES(SETUP_CYCLES)
  ) u_engine (
    .clock      (clock),
    .reset      (reset),
    .i_trig     (w_trig),
    .i_trig_page(cpu_wdata),
    .i_mem_rdata(mem_rdata),
    .o_state    (w_state),
    .o_src_page (w_src_page),
    .o_index    (w_index),
    .o_latch    (w_latch),
    .o_reg_rdata(w_reg_rdata)
  );

  assign w_dma_owns = (w_state == ST_READ) || (w_state == ST_WRITE);
  assign dma_active = (w_state != ST_IDLE);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rd    = cpu_rd && !w_reg_hit;
    mem_wr    = cpu_wr && !w_reg_hit;
    cpu_rdata = OPEN_BUS;
    if (cpu_rd) cpu_rdata = w_reg_hit ? w_reg_rdata : mem_rdata;
    // While the engine owns the bus, CPU traffic other than the DMA register sees open bus.
    if (w_dma_owns) begin
      mem_rd    = (w_state == ST_READ);
      mem_wr    = (w_state == ST_WRITE);
      mem_addr  = (w_state == ST_READ) ? {w_src_page, w_index} : (OAM_BASE + {8'h00, w_index});
      mem_wdata = w_latch;
      if (cpu_rd && !w_reg_hit) cpu_rdata = OPEN_BUS;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter_mod.sv
// Bench for oam_dma_arbiter_mod: directed copies, blocking, echo page, restart, async reset, readback.
module tb_oam_dma_arbiter_mod;

  localparam int SETUP = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  int checks = 0;
  int errors = 0;

  oam_dma_arbiter_mod dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .dma_active(dma_active)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  // System memory: filled with pat() on the first edge, then written by the bus.
  logic [7:0] mem [0:65535];
  bit         mem_init_done = 1'b0;
  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
      mem_init_done <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Transfer model: cycles elapsed since the last trigger and the page it wrote.
  bit         m_active;
  int         m_off;
  logic [7:0] m_page;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_off    <= 0;
      m_page   <= 8'h00;
    end else if (cpu_wr && cpu_addr == 16'hFF46) begin
      m_active <= 1'b1;
      m_off    <= 1;
      m_page   <= cpu_wdata;
    end else if (m_active) begin
      if (m_off == SETUP + 320) m_active <= 1'b0;
      m_off <= m_off + 1;
    end
  end

  always @(negedge clock) begin
    logic [15:0] ea;
    logic [7:0]  ew, wm, er, sp, idx, rb;
    logic        erd, ewr, eact, hit, dma_bus;
    logic [34:0] act_v, exp_v;
    int          j;
`ifdef OAM_DMA_READBACK_EN
    rb = m_page;
`else
    rb = 8'hFF;
`endif
    hit     = (cpu_addr == 16'hFF46);
    eact    = !reset && m_active;
    dma_bus = eact && (m_off > SETUP);
    if (dma_bus) begin
      j   = m_off - SETUP - 1;
      idx = 8'(j / 2);
      sp  = (m_page >= 8'hE0) ? (m_page - 8'h20) : m_page;
      if (j % 2 == 0) begin
        ea = {sp, idx}; ew = 8'h00; wm = 8'h00; erd = 1'b1; ewr = 1'b0;
      end else begin
        ea = 16'hFE00 + {8'h00, idx}; ew = pat({sp, idx}); wm = 8'hFF; erd = 1'b0; ewr = 1'b1;
      end
      er = (cpu_rd && hit) ? rb : 8'hFF;
    end else begin
      ea = cpu_addr; ew = cpu_wdata; wm = 8'hFF;
      erd = cpu_rd && !hit; ewr = cpu_wr && !hit;
      er = cpu_rd ? (hit ? rb : mem[cpu_addr]) : 8'hFF;
    end
    act_v = {mem_addr, mem_wdata & wm, mem_rd, mem_wr, cpu_rdata, dma_active};
    exp_v = {ea, ew & wm, erd, ewr, er, eact};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL bus_cycle t=%0t: got {addr,wdata,rd,wr,rdata,act}=%h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic trigger(input logic [7:0] page);
    drive(1'b0, 1'b1, 16'hFF46, page);
    @(negedge clock);
    check("trig_mem_wr", 32'(mem_wr), 32'd0);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Runs until dma_active falls, poking blocked CPU accesses mid-copy.
  task automatic run_copy(output int act, output int ops, output logic [15:0] faddr, output int fcyc);
    bit done = 1'b0;
    bit seen = 1'b0;
    act = 0; ops = 0; faddr = 16'hFFFF; fcyc = -1;
    for (int k = 1; k <= 400 && !done; k++) begin
      if (k == 50)      drive(1'b1, 1'b0, 16'hC000, 8'h00);
      else if (k == 60) drive(1'b0, 1'b1, 16'hC000, 8'h55);
      else              drive(1'b0, 1'b0, 16'h0000, 8'h00);
      @(negedge clock);
      if (k == 50) check("blocked_rd_rdata", 32'(cpu_rdata), 32'h0000_00FF);
      if (mem_rd && !seen) begin seen = 1'b1; faddr = mem_addr; fcyc = k; end
      if (mem_rd || mem_wr) ops++;
      if (dma_active) act++; else done = 1'b1;
      step();
    end
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    check("copy_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int act, ops, fcyc, bad, strobes;
    logic [15:0] faddr;
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clock);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0000_00FF);
    step();
    reset = 1'b0;
    step();

    // Plain copy from C100, with CPU read/write of C000 blocked mid-copy.
    trigger(8'hC1);
    run_copy(act, ops, faddr, fcyc);
    check("c1_active_cycles", 32'(act), 32'd321);
    check("c1_bus_ops", 32'(ops), 32'd320);
    check("c1_first_rd_addr", 32'(faddr), 32'h0000_C100);
    check("c1_first_rd_cycle", 32'(fcyc), 32'd2);
    check("c1_oam_fe00", 32'(mem[16'hFE00]), 32'h0000_009B);
    check("c1_oam_fe9f", 32'(mem[16'hFE9F]), 32'h0000_0004);
    check("c000_unchanged", 32'(mem[16'hC000]), 32'h0000_009A);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== pat(16'hC100 + 16'(i))) bad++;
    check("c1_oam_all_bytes", 32'(bad), 32'd0);

    // Echo page E3 sources from C300.
    trigger(8'hE3);
    run_copy(act, ops, faddr, fcyc);
    check("e3_first_rd_addr", 32'(faddr), 32'h0000_C300);
    check("e3_oam_fe05", 32'(mem[16'hFE05]), 32'h0000_009C);

    // Restart at index 80 with page D0.
    trigger(8'hC1);
    for (int k = 0; k < 161; k++) step();
    drive(1'b0, 1'b1, 16'hFF46, 8'hD0);
    @(negedge clock);
    check("restart_rd_completes", 32'(mem_rd), 32'd1);
    check("restart_rd_addr", 32'(mem_addr), 32'h0000_C150);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clock);
    check("restart_setup_rd", 32'(mem_rd), 32'd0);
    check("restart_setup_active", 32'(dma_active), 32'd1);
    step();
    run_copy(act, ops, faddr, fcyc);
    check("restart_bus_ops", 32'(ops), 32'd320);
    check("restart_first_rd_addr", 32'(faddr), 32'h0000_D000);
    check("restart_oam_fe00", 32'(mem[16'hFE00]), 32'h0000_008A);
    check("restart_oam_fe9f", 32'(mem[16'hFE9F]), 32'h0000_0015);

    // Async reset while writing index 10.
    trigger(8'hC1);
    for (int k = 0; k < 22; k++) step();
    check("pre_reset_wr", 32'(mem_wr), 32'd1);
    check("pre_reset_addr", 32'(mem_addr), 32'h0000_FE0A);
    reset = 1'b1;
    #1;
    check("reset_mem_wr_drop", 32'(mem_wr), 32'd0);
    check("reset_mem_rd_drop", 32'(mem_rd), 32'd0);
    check("reset_active_drop", 32'(dma_active), 32'd0);
    step();
    step();
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mem_rd || mem_wr || dma_active) strobes++;
      step();
    end
    check("post_reset_quiet", 32'(strobes), 32'd0);

    // DMA register readback: idle after reset, then during SETUP of a new copy.
    drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    @(negedge clock);
`ifdef OAM_DMA_READBACK_EN
    check("readback_after_reset", 32'(cpu_rdata), 32'h0000_0000);
`else
    check("readback_after_reset", 32'(cpu_rdata), 32'h0000_00FF);
`endif
    check("readback_idle_mem_rd", 32'(mem_rd), 32'd0);
    step();
    trigger(8'hC1);
    drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    @(negedge clock);
`ifdef OAM_DMA_READBACK_EN
    check("readback_page", 32'(cpu_rdata), 32'h0000_00C1);
`else
    check("readback_page", 32'(cpu_rdata), 32'h0000_00FF);
`endif
    check("readback_mem_rd", 32'(mem_rd), 32'd0);
    step();
    run_copy(act, ops, faddr, fcyc);
    check("readback_copy_ops", 32'(ops), 32'd320);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
